// File: rtl/bsg_cover_pkg.sv
// Shared definitions for the coverage drain stream (sender and receiver).
package bsg_cover_pkg;

    // Bit positions within the sticky error vector
    localparam int unsigned e_cover_err_cfg   = 0;
    localparam int unsigned e_cover_err_frame = 1;
    localparam int unsigned e_cover_err_count = 2;
    localparam int unsigned cover_err_w       = 3;

    // Beats needed to carry one entry of 'width' bits over an 'out_width' bus
    function automatic int unsigned cdiv(input int unsigned width, input int unsigned out_width);
        return (width + out_width - 1) / out_width;
    endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO; accepts a push while full if a pop happens in the same cycle.
module bsg_two_fifo #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               full_n_c
);

    localparam int unsigned cnt_w_lp = 2;

    logic [width_p-1:0]  mem_r [2];
    logic                rptr_r, rptr_n;
    logic                wptr_r, wptr_n;
    logic [cnt_w_lp-1:0] cnt_r, cnt_n;
    logic                enq, deq;

    // Handshake qualification and next pointer/occupancy
    always_comb begin
        deq      = yumi_i & (cnt_r != '0);
        enq      = v_i & ((cnt_r != cnt_w_lp'(2)) | deq);
        rptr_n   = rptr_r ^ deq;
        wptr_n   = wptr_r ^ enq;
        cnt_n    = cnt_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        full_n_c = (cnt_n == cnt_w_lp'(2));
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rptr_r   <= 1'b0;
            wptr_r   <= 1'b0;
            cnt_r    <= '0;
        end else begin
            if (enq) begin
                mem_r[wptr_r] <= data_i;
            end
            rptr_r <= rptr_n;
            wptr_r <= wptr_n;
            cnt_r  <= cnt_n;
        end
    end

    assign v_o    = (cnt_r != '0);
    assign data_o = mem_r[rptr_r];

endmodule

// File: rtl/bsg_cover_rx.sv
// Coverage drain receiver: reassembles beats into entries and checks burst framing.
module bsg_cover_rx
    import bsg_cover_pkg::*;
#(
    parameter int unsigned width_p    = 40,
    parameter int unsigned in_width_p = 32,
    parameter int unsigned els_p      = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [7:0]             els_i,
    input  logic [7:0]             len_i,
    input  logic                   v_i,
    output logic                   ready_and_o,
    input  logic                   last_i,
    input  logic [in_width_p-1:0]  data_i,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    output logic                   last_o,
    input  logic                   ready_and_i,
    output logic [31:0]            burst_count_o,
    output logic [cover_err_w-1:0] err_o,
    input  logic                   err_clear_i
);

    localparam int unsigned len_lp     = cdiv(width_p, in_width_p);
    localparam int unsigned shift_w_lp = (len_lp > 1) ? (len_lp - 1) * in_width_p : in_width_p;
    localparam int unsigned beat_w_lp  = (len_lp > 1) ? $clog2(len_lp) : 1;
    localparam int unsigned ent_w_lp   = $clog2(els_p + 1);

    logic [shift_w_lp-1:0]  shift_r, shift_n;
    logic [beat_w_lp-1:0]   beat_r, beat_n;
    logic [ent_w_lp-1:0]    ent_r, ent_n, ent_inc;
    logic [31:0]            burst_r, burst_n;
    logic [cover_err_w-1:0] err_r, err_n, err_set;
    logic                   ready_r, ready_n;

    logic                   acc, at_end, burst_full;
    logic                   push_v, push_last;
    logic [width_p-1:0]     push_data;
    logic                   fifo_v, fifo_full_n;
    logic [width_p:0]       fifo_data;

    // Beat assembly, entry/burst counting and framing checks
    always_comb begin
        shift_n    = shift_r;
        beat_n     = beat_r;
        ent_n      = ent_r;
        burst_n    = burst_r;
        err_set    = '0;
        push_v     = 1'b0;
        push_last  = 1'b0;
        acc        = v_i & ready_r;
        at_end     = (beat_r == beat_w_lp'(len_lp - 1));
        ent_inc    = ent_r + ent_w_lp'(1);
        burst_full = (ent_inc == ent_w_lp'(els_p));
        push_data  = width_p'({shift_r, data_i});

        if ((els_i != 8'(els_p)) || (len_i != 8'(len_lp))) begin
            err_set[e_cover_err_cfg] = 1'b1;
        end

        if (acc) begin
            shift_n = shift_w_lp'({shift_r, data_i});
            if (last_i && !at_end) begin
                // Burst ended mid-entry: drop the partial entry
                err_set[e_cover_err_frame] = 1'b1;
                beat_n = '0;
                ent_n  = '0;
            end else if (at_end) begin
                push_v = 1'b1;
                beat_n = '0;
                if (last_i || burst_full) begin
                    // Close the burst, either normally or forced by the entry count
                    push_last = 1'b1;
                    ent_n     = '0;
                    if (last_i && burst_full) begin
                        burst_n = burst_r + 32'd1;
                    end else begin
                        err_set[e_cover_err_count] = 1'b1;
                    end
                end else begin
                    ent_n = ent_inc;
                end
            end else begin
                beat_n = beat_r + beat_w_lp'(1);
            end
        end

        err_n = (err_clear_i ? '0 : err_r) | err_set;
    end

    // Stall only when the next beat completes an entry and the buffer will be full
    always_comb begin
        ready_n = 1'b1;
        if ((beat_n == beat_w_lp'(len_lp - 1)) && fifo_full_n) begin
            ready_n = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            shift_r <= '0;
            beat_r  <= '0;
            ent_r   <= '0;
            burst_r <= '0;
            err_r   <= '0;
            ready_r <= 1'b1;
        end else begin
            shift_r <= shift_n;
            beat_r  <= beat_n;
            ent_r   <= ent_n;
            burst_r <= burst_n;
            err_r   <= err_n;
            ready_r <= ready_n;
        end
    end

    bsg_two_fifo #(
        .width_p (width_p + 1)
    ) u_out_fifo (
        .clk      (aclk),
        .reset_n  (aresetn),
        .v_i      (push_v),
        .data_i   ({push_last, push_data}),
        .v_o      (fifo_v),
        .data_o   (fifo_data),
        .yumi_i   (ready_and_i),
        .full_n_c (fifo_full_n)
    );

    assign ready_and_o   = ready_r;
    assign v_o           = fifo_v;
    assign data_o        = fifo_data[width_p-1:0];
    assign last_o        = fifo_data[width_p];
    assign burst_count_o = burst_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_bsg_cover_rx.sv
// Randomized + directed bench for bsg_cover_rx against a queue-based entry model.
module tb_bsg_cover_rx;

    localparam int unsigned W   = 40;
    localparam int unsigned IW  = 32;
    localparam int unsigned ELS = 4;
    localparam int unsigned LEN = 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  els_i = 8'd4;
    logic [7:0]  len_i = 8'd2;
    logic        v_i = 1'b0;
    logic        ready_and_o;
    logic        last_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        v_o;
    logic [39:0] data_o;
    logic        last_o;
    logic        ready_and_i = 1'b1;
    logic [31:0] burst_count_o;
    logic [2:0]  err_o;
    logic        err_clear_i = 1'b0;

    logic        p_v = 1'b0;
    logic        p_ready_o;
    logic [31:0] p_data = '0;
    logic        p_v_o;
    logic [15:0] p_data_o;
    logic        p_last_o;
    logic [31:0] p_burst;
    logic [2:0]  p_err;

    always #5 aclk = ~aclk;

    bsg_cover_rx #(.width_p(W), .in_width_p(IW), .els_p(ELS)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .els_i(els_i), .len_i(len_i),
        .v_i(v_i), .ready_and_o(ready_and_o), .last_i(last_i), .data_i(data_i),
        .v_o(v_o), .data_o(data_o), .last_o(last_o), .ready_and_i(ready_and_i),
        .burst_count_o(burst_count_o), .err_o(err_o), .err_clear_i(err_clear_i)
    );

    bsg_cover_rx #(.width_p(16), .in_width_p(32), .els_p(4)) u_pass (
        .aclk(aclk), .aresetn(aresetn), .els_i(8'd4), .len_i(8'd1),
        .v_i(p_v), .ready_and_o(p_ready_o), .last_i(1'b0), .data_i(p_data),
        .v_o(p_v_o), .data_o(p_data_o), .last_o(p_last_o), .ready_and_i(1'b1),
        .burst_count_o(p_burst), .err_o(p_err), .err_clear_i(1'b0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_beat = 0;
    int          m_ent = 0;
    logic [63:0] m_val = '0;
    logic [40:0] m_q[$];
    logic [31:0] m_burst = '0;
    logic [2:0]  m_err = '0;
    bit          m_ready = 1'b1;
    bit          m_acc = 1'b0;
    bit          chk_en = 1'b0;

    // Entry-level model: beats are collected into a value, completed entries queue up
    always @(posedge aclk) begin : model
        bit         acc, pop, closed, full_burst;
        logic [2:0] set;
        if (!aresetn) begin
            m_beat = 0; m_ent = 0; m_val = '0; m_q.delete();
            m_burst = '0; m_err = '0; m_ready = 1'b1; m_acc = 1'b0;
        end else begin
            acc = v_i && m_ready;
            pop = (m_q.size() != 0) && ready_and_i;
            set = '0;
            if (els_i != 8'(ELS) || len_i != 8'(LEN)) set[0] = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_val = (m_val << IW) | 64'(data_i);
                m_beat++;
                if (last_i && m_beat != int'(LEN)) begin
                    set[1] = 1'b1;
                    m_beat = 0;
                    m_ent = 0;
                end else if (m_beat == int'(LEN)) begin
                    m_ent++;
                    full_burst = (m_ent == int'(ELS));
                    closed = last_i || full_burst;
                    if (last_i && full_burst) m_burst++;
                    else if (closed) set[2] = 1'b1;
                    m_q.push_back({closed, m_val[W-1:0]});
                    m_beat = 0;
                    if (closed) m_ent = 0;
                end
            end
            m_err = (err_clear_i ? 3'b000 : m_err) | set;
            m_ready = !(m_beat == int'(LEN) - 1 && m_q.size() == 2);
            m_acc = acc;
        end
    end

    logic [40:0] got_q[$];

    // Compare DUT against model every cycle; log popped entries
    always @(negedge aclk) begin
        if (chk_en) begin
            check("ready_and_o", 64'(ready_and_o), 64'(m_ready));
            check("v_o", 64'(v_o), 64'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("data_o", 64'(data_o), 64'(m_q[0][W-1:0]));
                check("last_o", 64'(last_o), 64'(m_q[0][W]));
            end
            check("burst_count_o", 64'(burst_count_o), 64'(m_burst));
            check("err_o", 64'(err_o), 64'(m_err));
            if (v_o && ready_and_i) got_q.push_back({last_o, data_o});
        end
    end

    // ---------------- stimulus ----------------
    logic [39:0] sent_q[$];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        v_i = 1'b0;
        last_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        v_i = 1'b1;
        data_i = d;
        last_i = l;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (m_acc) begin
                v_i = 1'b0;
                last_i = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: beat %0h not accepted within 200 cycles", d);
        v_i = 1'b0;
        last_i = 1'b0;
    endtask

    function automatic logic [39:0] rand40();
        return {8'($urandom), 32'($urandom)};
    endfunction

    task automatic send_entry(input logic [39:0] e, input logic l);
        logic [23:0] pad;
        pad = 24'($urandom);
        send_beat({pad, e[39:32]}, 1'b0);
        send_beat(e[31:0], l);
        sent_q.push_back(e);
    endtask

    task automatic pulse_clear();
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
    endtask

    bit bp_stop = 1'b0;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [39:0] e;
        logic [31:0] b6;
        logic [31:0] bc0;

        // Reset
        repeat (2) @(posedge aclk);
        #1;
        chk_en = 1'b1;
        tick();
        check("rst_ready", 64'(ready_and_o), 64'd1);
        check("rst_v", 64'(v_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_last", 64'(last_o), 64'd0);
        check("rst_burst", 64'(burst_count_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        aresetn = 1'b1;
        tick();

        // Pass mode on the narrow instance
        p_v = 1'b1;
        p_data = 32'h1234BEEF;
        tick();
        p_v = 1'b0;
        @(negedge aclk);
        check("pass_v", 64'(p_v_o), 64'd1);
        check("pass_data", 64'(p_data_o), 64'hBEEF);
        check("pass_last", 64'(p_last_o), 64'd0);
        check("pass_err", 64'(p_err), 64'd0);
        check("pass_burst", 64'(p_burst), 64'd0);
        tick();

        // Directed first burst
        got_q.delete();
        send_beat(32'h000000AB, 1'b0);
        send_beat(32'hCDEF0123, 1'b0);
        for (int i = 1; i < 4; i++) send_entry(rand40(), (i == 3));
        idle(4);
        check("dir_count", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            check("dir_entry0", 64'(got_q[0]), 64'h00ABCDEF0123);
            check("dir_last0", 64'(got_q[0][40]), 64'd0);
            check("dir_last1", 64'(got_q[1][40]), 64'd0);
            check("dir_last2", 64'(got_q[2][40]), 64'd0);
            check("dir_last3", 64'(got_q[3][40]), 64'd1);
        end
        check("dir_burst", 64'(burst_count_o), 64'd1);
        check("dir_err", 64'(err_o), 64'd0);

        // Backpressure: downstream stalled across a burst
        got_q.delete();
        sent_q.delete();
        ready_and_i = 1'b0;
        send_entry(rand40(), 1'b0);
        send_entry(rand40(), 1'b0);
        e = rand40();
        send_beat({24'h0, e[39:32]}, 1'b0);
        check("bp_ready_low", 64'(ready_and_o), 64'd0);
        b6 = e[31:0];
        v_i = 1'b1;
        data_i = b6;
        repeat (3) tick();
        check("bp_held", 64'(ready_and_o), 64'd0);
        ready_and_i = 1'b1;
        send_beat(b6, 1'b0);
        sent_q.push_back(e);
        send_entry(rand40(), 1'b1);
        idle(4);
        check("bp_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("bp_order", 64'(got_q[i][39:0]), 64'(sent_q[i]));

        // Misframe: last on the first beat of entry 1
        got_q.delete();
        sent_q.delete();
        send_entry(rand40(), 1'b0);
        send_beat(32'($urandom), 1'b1);
        idle(3);
        check("mis_err", 64'(err_o), 64'b010);
        check("mis_count", 64'(got_q.size()), 64'd1);
        pulse_clear();
        check("mis_clear", 64'(err_o), 64'd0);
        bc0 = burst_count_o;
        for (int i = 0; i < 4; i++) send_entry(rand40(), (i == 3));
        idle(3);
        check("mis_next_count", 64'(got_q.size()), 64'd5);
        if (got_q.size() == 5) check("mis_next_last", 64'(got_q[4][40]), 64'd1);
        check("mis_next_burst", 64'(burst_count_o), 64'(bc0 + 32'd1));

        // Five entries without last: force-close after four
        got_q.delete();
        bc0 = burst_count_o;
        for (int i = 0; i < 5; i++) send_entry(rand40(), 1'b0);
        idle(3);
        check("nolast_err", 64'(err_o), 64'b100);
        check("nolast_count", 64'(got_q.size()), 64'd5);
        if (got_q.size() == 5) begin
            check("nolast_last2", 64'(got_q[2][40]), 64'd0);
            check("nolast_last3", 64'(got_q[3][40]), 64'd1);
            check("nolast_last4", 64'(got_q[4][40]), 64'd0);
        end
        for (int i = 0; i < 3; i++) send_entry(rand40(), (i == 2));
        idle(3);
        check("nolast_burst", 64'(burst_count_o), 64'(bc0 + 32'd1));
        pulse_clear();

        // Config mismatch and clear/set priority
        len_i = 8'd3;
        tick();
        tick();
        check("cfg_err", 64'(err_o), 64'b001);
        err_clear_i = 1'b1;
        tick();
        check("cfg_set_wins", 64'(err_o), 64'b001);
        len_i = 8'd2;
        tick();
        err_clear_i = 1'b0;
        check("cfg_cleared", 64'(err_o), 64'd0);

        // Random traffic with random downstream stalls, stray last and clears
        bp_stop = 1'b0;
        fork
            begin
                while (!bp_stop) begin
                    ready_and_i = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    err_clear_i = ($urandom_range(0, 15) == 0);
                    if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
                    send_beat($urandom, ($urandom_range(0, 9) == 0));
                end
                err_clear_i = 1'b0;
                bp_stop = 1'b1;
            end
        join
        ready_and_i = 1'b1;
        idle(5);

        // Reset mid-entry with a buffered entry
        pulse_clear();
        ready_and_i = 1'b0;
        send_entry(rand40(), 1'b0);
        send_beat(32'($urandom), 1'b0);
        aresetn = 1'b0;
        tick();
        check("mrst_v", 64'(v_o), 64'd0);
        check("mrst_data", 64'(data_o), 64'd0);
        check("mrst_last", 64'(last_o), 64'd0);
        check("mrst_ready", 64'(ready_and_o), 64'd1);
        check("mrst_burst", 64'(burst_count_o), 64'd0);
        check("mrst_err", 64'(err_o), 64'd0);
        aresetn = 1'b1;
        ready_and_i = 1'b1;
        got_q.delete();
        e = rand40();
        send_entry(e, 1'b0);
        idle(3);
        check("mrst_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) check("mrst_entry", 64'(got_q[0][39:0]), 64'(e));

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
